// File: rtl/mnk_pkg.sv
// Shared types for the N x N, K-in-a-row game controller: FSM states,
// player identities and winner encodings.
package mnk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } game_state_t;

   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_t;

   function automatic winner_t winner_of(player_t p);
      return (p == P2) ? WIN_P2 : WIN_P1;
   endfunction

endpackage

// File: rtl/mnk_game_control_btn_debounce.sv
// Single-button debouncer: the level flips after DEB_CYCLES consecutive cycles
// of disagreement with the raw input; rise flags the debounced 0->1 edge.
module btn_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             prev_q;

   // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         prev_q <= level_q;
         if (raw == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            level_q <= raw;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/mnk_game_control.sv
// N x N, K-in-a-row two-player game controller: debounced cell buttons,
// ownership tracking, win/draw detection for the player who just moved.
module mnk_game_control
   import mnk_pkg::*;
#(
   parameter int N          = 3,
   parameter int K          = 3,
   parameter int DEB_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N*N-1:0]    btn,
   input  logic              start,
   input  logic              first_player,
   output logic [N*N-1:0]    cell_taken,
   output logic [N*N-1:0]    cell_owner,
   output logic              curr_player,
   output game_state_t       game_state,
   output logic [1:0]        winner,
   output logic              draw,
   output logic              illegal
);

   localparam int CELLS = N * N;
   localparam int IDX_W = $clog2(CELLS);
   localparam int CNT_W = $clog2(CELLS + 1);

   logic [CELLS-1:0] btn_level, btn_rise, press, accept, mine;
   logic [4*CELLS-1:0] win_vec;
   logic             any_win;

   game_state_t      state_q, state_d;
   logic [CELLS-1:0] taken_q, taken_d, owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   player_t          player_q, player_d;
   winner_t          winner_q, winner_d;
   logic             draw_q, draw_d, illegal_q, illegal_d;
   logic [IDX_W-1:0] sel;

   for (genvar i = 0; i < CELLS; i++) begin : g_btn
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (btn[i]),
         .level (btn_level[i]),
         .rise  (btn_rise[i])
      );
   end

   assign press  = btn_rise & btn_level;
   assign accept = press & ~taken_q;
   assign mine   = taken_q & (player_q == P2 ? owner_q : ~owner_q);

   // One window per (direction, origin); direction 3 runs down-left (anti-diagonal).
   for (genvar d = 0; d < 4; d++) begin : g_dir
      localparam int DR = (d == 0) ? 0 : 1;
      localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      for (genvar r = 0; r < N; r++) begin : g_row
         for (genvar c = 0; c < N; c++) begin : g_col
            localparam int ER = r + DR * (K - 1);
            localparam int EC = c + DC * (K - 1);
            if (ER < N && EC >= 0 && EC < N) begin : g_win
               logic [K-1:0] seg;
               for (genvar k = 0; k < K; k++) begin : g_k
                  assign seg[k] = mine[(r + DR * k) * N + c + DC * k];
               end
               assign win_vec[d*CELLS + r*N + c] = &seg;
            end else begin : g_none
               assign win_vec[d*CELLS + r*N + c] = 1'b0;
            end
         end
      end
   end

   assign any_win = |win_vec;

   // NOTE: every variable gets its default first so no path through the case leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      taken_d   = taken_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      player_d  = player_q;
      winner_d  = winner_q;
      draw_d    = draw_q;
      illegal_d = 1'b0;
      sel       = '0;
      for (int i = CELLS - 1; i >= 0; i--) begin
         if (accept[i]) sel = IDX_W'(i);
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = PLAY;
               taken_d  = '0;
               owner_d  = '0;
               cnt_d    = '0;
               winner_d = WIN_NONE;
               draw_d   = 1'b0;
               player_d = player_t'(first_player);
            end
         end
         PLAY: begin
            if (|accept) begin
               taken_d[sel] = 1'b1;
               owner_d[sel] = player_q;
               cnt_d        = cnt_q + CNT_W'(1);
               state_d      = CHECK;
            end else if (|press) begin
               illegal_d = 1'b1;
            end
         end
         CHECK: begin
            if (any_win) begin
               state_d  = DONE;
               winner_d = winner_of(player_q);
            end else if (cnt_q == CNT_W'(CELLS)) begin
               state_d = DONE;
               draw_d  = 1'b1;
            end else begin
               state_d  = PLAY;
               player_d = player_t'(~player_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         taken_q   <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         player_q  <= P1;
         winner_q  <= WIN_NONE;
         draw_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         taken_q   <= taken_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         player_q  <= player_d;
         winner_q  <= winner_d;
         draw_q    <= draw_d;
         illegal_q <= illegal_d;
      end
   end

   assign cell_taken  = taken_q;
   assign cell_owner  = owner_q;
   assign curr_player = player_q;
   assign game_state  = state_q;
   assign winner      = winner_q;
   assign draw        = draw_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_mnk_game_control.sv
// Scoreboard bench for mnk_game_control: a board-level reference model queues the
// expected response to each stimulus; per-DUT monitors compare on every DUT event.
module tb_mnk_game_control;
   import mnk_pkg::*;

   localparam int D3 = 4;
   localparam int D5 = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [8:0]  btn3, taken3, owner3;
   logic        start3, fp3, cur3, draw3, ill3;
   logic [1:0]  win3;
   game_state_t st3;

   logic [24:0] btn5, taken5, owner5;
   logic        start5, fp5, cur5, draw5, ill5;
   logic [1:0]  win5;
   game_state_t st5;

   mnk_game_control #(.N(3), .K(3), .DEB_CYCLES(D3)) u3 (
      .clk(clk), .reset(reset), .btn(btn3), .start(start3), .first_player(fp3),
      .cell_taken(taken3), .cell_owner(owner3), .curr_player(cur3),
      .game_state(st3), .winner(win3), .draw(draw3), .illegal(ill3));

   mnk_game_control #(.N(5), .K(4), .DEB_CYCLES(D5)) u5 (
      .clk(clk), .reset(reset), .btn(btn5), .start(start5), .first_player(fp5),
      .cell_taken(taken5), .cell_owner(owner5), .curr_player(cur5),
      .game_state(st5), .winner(win5), .draw(draw5), .illegal(ill5));

   typedef struct packed {
      logic [1:0]  state;
      logic [63:0] taken;
      logic [63:0] owner;
      logic        player;
      logic [1:0]  winner;
      logic        draw;
      logic        illegal;
   } rec_t;

   rec_t q3[$];
   rec_t q5[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: -1 empty, 0 P1, 1 P2.
   int  m_own[2][64];
   bit  m_active[2];
   bit  m_player[2];
   int  m_cnt[2];

   function automatic int nn(int d);  return (d == 0) ? 3 : 5;   endfunction
   function automatic int kk(int d);  return (d == 0) ? 3 : 4;   endfunction
   function automatic int deb(int d); return (d == 0) ? D3 : D5; endfunction

   function automatic rec_t mk_rec(int d, logic [1:0] st, logic [1:0] w, bit dr, bit il);
      rec_t r;
      r = '0;
      for (int i = 0; i < nn(d) * nn(d); i++) begin
         r.taken[i] = (m_own[d][i] >= 0);
         r.owner[i] = (m_own[d][i] == 1);
      end
      r.state   = st;
      r.player  = m_player[d];
      r.winner  = w;
      r.draw    = dr;
      r.illegal = il;
      return r;
   endfunction

   function automatic bit model_win(int d);
      int dr[4] = '{0, 1, 1, 1};
      int dc[4] = '{1, 0, 1, -1};
      int n = nn(d);
      int p = int'(m_player[d]);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            for (int x = 0; x < 4; x++) begin
               bit ok = 1'b1;
               for (int s = 0; s < kk(d); s++) begin
                  int rr = r + dr[x] * s;
                  int cc = c + dc[x] * s;
                  if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
                  else if (m_own[d][rr * n + cc] != p) ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   task automatic push(int d, rec_t r);
      if (d == 0) q3.push_back(r);
      else        q5.push_back(r);
   endtask

   task automatic model_clear(int d);
      for (int i = 0; i < 64; i++) m_own[d][i] = -1;
      m_cnt[d] = 0;
   endtask

   task automatic model_apply(int d, logic [63:0] mask);
      int sel = -1;
      int n = nn(d);
      if (!m_active[d] || mask == 64'd0) return;
      for (int i = n * n - 1; i >= 0; i--)
         if (mask[i] && m_own[d][i] < 0) sel = i;
      if (sel < 0) begin
         push(d, mk_rec(d, PLAY, 2'b00, 1'b0, 1'b1));
         return;
      end
      m_own[d][sel] = int'(m_player[d]);
      m_cnt[d]++;
      push(d, mk_rec(d, CHECK, 2'b00, 1'b0, 1'b0));
      if (model_win(d)) begin
         push(d, mk_rec(d, DONE, m_player[d] ? 2'b10 : 2'b01, 1'b0, 1'b0));
         m_active[d] = 1'b0;
      end else if (m_cnt[d] == n * n) begin
         push(d, mk_rec(d, DONE, 2'b00, 1'b1, 1'b0));
         m_active[d] = 1'b0;
      end else begin
         m_player[d] = ~m_player[d];
         push(d, mk_rec(d, PLAY, 2'b00, 1'b0, 1'b0));
      end
   endtask

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_rec(string name, rec_t e, rec_t a);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got st=%0d tk=%h ow=%h pl=%0d w=%0d dr=%0d il=%0d, expected st=%0d tk=%h ow=%h pl=%0d w=%0d dr=%0d il=%0d",
                  name, a.state, a.taken, a.owner, a.player, a.winner, a.draw, a.illegal,
                  e.state, e.taken, e.owner, e.player, e.winner, e.draw, e.illegal);
      end
   endtask

   // Monitors: an event is any state change or an illegal pulse.
   game_state_t prev3 = IDLE, prev5 = IDLE;
   rec_t act3, act5;

   always @(negedge clk) begin
      if (!reset && (st3 != prev3 || ill3)) begin
         act3 = '0;
         act3.state = st3; act3.taken[8:0] = taken3; act3.owner[8:0] = owner3;
         act3.player = cur3; act3.winner = win3; act3.draw = draw3; act3.illegal = ill3;
         if (q3.size() == 0) check_rec("dut3_unexpected_event", '0, act3);
         else                check_rec("dut3_event", q3.pop_front(), act3);
      end
      prev3 = st3;
   end

   always @(negedge clk) begin
      if (!reset && (st5 != prev5 || ill5)) begin
         act5 = '0;
         act5.state = st5; act5.taken[24:0] = taken5; act5.owner[24:0] = owner5;
         act5.player = cur5; act5.winner = win5; act5.draw = draw5; act5.illegal = ill5;
         if (q5.size() == 0) check_rec("dut5_unexpected_event", '0, act5);
         else                check_rec("dut5_event", q5.pop_front(), act5);
      end
      prev5 = st5;
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(int d, logic [63:0] mask);
      if (d == 0) btn3 = mask[8:0];
      else        btn5 = mask[24:0];
   endtask

   task automatic do_start(int d, bit fp);
      if (!m_active[d]) begin
         model_clear(d);
         m_player[d] = fp;
         m_active[d] = 1'b1;
         push(d, mk_rec(d, PLAY, 2'b00, 1'b0, 1'b0));
      end
      if (d == 0) begin fp3 = fp; start3 = 1'b1; end
      else        begin fp5 = fp; start5 = 1'b1; end
      tick(1);
      start3 = 1'b0;
      start5 = 1'b0;
      tick(2);
   endtask

   task automatic press(int d, logic [63:0] mask);
      model_apply(d, mask);
      set_btn(d, mask);
      tick(deb(d) + 3);
      set_btn(d, 64'd0);
      tick(deb(d) + 3);
   endtask

   task automatic glitch(int d, logic [63:0] mask);
      set_btn(d, mask);
      tick(deb(d) - 1);
      set_btn(d, 64'd0);
      tick(deb(d) + 3);
   endtask

   task automatic press_seq(int d, int cells[]);
      foreach (cells[i]) press(d, 64'd1 << cells[i]);
   endtask

   task automatic check_reset_values(string tag);
      check({tag, "_state"},   64'(st3), 64'(IDLE));
      check({tag, "_taken"},   64'(taken3), 64'd0);
      check({tag, "_owner"},   64'(owner3), 64'd0);
      check({tag, "_flags"},   {59'd0, cur3, win3, draw3, ill3}, 64'd0);
      check({tag, "_state5"},  64'(st5), 64'(IDLE));
      check({tag, "_taken5"},  64'(taken5), 64'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not end, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      btn3 = '0; btn5 = '0;
      start3 = 1'b0; start5 = 1'b0; fp3 = 1'b0; fp5 = 1'b0;
      for (int d = 0; d < 2; d++) begin
         model_clear(d);
         m_active[d] = 1'b0;
         m_player[d] = 1'b0;
      end
      tick(3);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      tick(2);

      // P1 completes the top row.
      do_start(0, 1'b0);
      press_seq(0, '{0, 3, 1, 4, 2});
      check("row_win_state",  64'(st3), 64'(DONE));
      check("row_win_winner", 64'(win3), 64'h1);
      check("row_win_taken",  64'(taken3), 64'h1F);
      check("row_win_owner",  64'(owner3), 64'h18);
      press(0, 64'd1 << 8);   // dropped in DONE
      check("done_holds_taken", 64'(taken3), 64'h1F);

      // Full board, no line.
      do_start(0, 1'b0);
      press_seq(0, '{0, 1, 2, 4, 3, 5, 7, 6, 8});
      check("draw_flag",   64'(draw3), 64'd1);
      check("draw_winner", 64'(win3), 64'd0);

      // Illegal press on an occupied cell, then debounce glitch and move latency.
      do_start(0, 1'b0);
      press(0, 64'd1 << 4);
      press(0, 64'd1 << 4);
      check("illegal_player", 64'(cur3), 64'd1);
      check("illegal_board",  64'(taken3), 64'h10);
      glitch(0, 64'd1 << 0);
      check("glitch_no_move", 64'(taken3), 64'h10);
      begin
         int edges = 0;
         model_apply(0, 64'd1 << 0);
         btn3 = 9'd1;
         for (int i = 1; i <= 20 && edges == 0; i++) begin
            @(posedge clk); #1;
            if (st3 == CHECK) edges = i;
         end
         check("move_latency_edges", 64'(edges), 64'(D3 + 1));
         tick(3);
         btn3 = '0;
         tick(D3 + 3);
      end

      // Simultaneous presses on 2 and 5, then reset mid-game.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      m_active[0] = 1'b0;
      tick(2);
      do_start(0, 1'b0);
      press(0, (64'd1 << 2) | (64'd1 << 5));
      check("simul_lowest_only", 64'(taken3), 64'h4);
      press(0, 64'd1 << 0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("midgame_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         model_clear(d);
         m_active[d] = 1'b0;
         m_player[d] = 1'b0;
      end
      tick(2);

      // 5x5, K=4: P2 first, wins on the anti-diagonal 4-8-12-16.
      do_start(1, 1'b1);
      press_seq(1, '{4, 0, 8, 1, 12, 5, 16});
      check("anti_diag_state",  64'(st5), 64'(DONE));
      check("anti_diag_winner", 64'(win5), 64'h2);

      // Randomised games on both boards.
      for (int g = 0; g < 14; g++) begin
         int d = (g % 4 == 3) ? 1 : 0;
         int cells = nn(d) * nn(d);
         do_start(d, 1'($urandom_range(0, 1)));
         for (int mv = 0; mv < 40 && m_active[d]; mv++) begin
            int r = $urandom_range(0, 9);
            int i = $urandom_range(0, cells - 1);
            int j = (i + 1 + $urandom_range(0, cells - 2)) % cells;
            if (r == 0)      glitch(d, 64'd1 << i);
            else if (r == 1) press(d, (64'd1 << i) | (64'd1 << j));
            else if (r == 2) do_start(d, 1'($urandom_range(0, 1)));
            else             press(d, 64'd1 << i);
         end
      end

      tick(20);
      check("dut3_queue_drained", 64'(q3.size()), 64'd0);
      check("dut5_queue_drained", 64'(q5.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
